// File: rtl/pipelined_mantissa_alu.sv
// Pipelined aligned-mantissa add/subtract with sticky borrow correction, result flags
// and leading-zero count, behind valid/ready handshakes on both sides.
module pipelined_mantissa_alu #(
    parameter int MANT_W     = 24,
    parameter int PIPE_DEPTH = 2,
    parameter int TAG_W      = 4,
    localparam int LZC_W     = $clog2(MANT_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_bypass,
    input  logic              in_sign_a,
    input  logic              in_sign_b,
    input  logic [MANT_W-1:0] in_mant_a,
    input  logic [MANT_W-1:0] in_mant_b,
    input  logic              in_shift_ovf,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] out_result,
    output logic              out_carry,
    output logic              out_sign,
    output logic              out_zero,
    output logic [LZC_W-1:0]  out_lzc,
    output logic              out_bypass,
    output logic [TAG_W-1:0]  out_tag
);

    function automatic logic [LZC_W-1:0] lzc_f(input logic [MANT_W-1:0] v);
        logic [LZC_W-1:0] n;
        logic             hit;
        n   = '0;
        hit = 1'b0;
        for (int i = MANT_W - 1; i >= 0; i--) begin
            if (!hit && !v[i]) begin
                n = n + LZC_W'(1);
            end else begin
                hit = 1'b1;
            end
        end
        return n;
    endfunction

    logic                  ready_en_r;
    logic [PIPE_DEPTH-1:0] valid_r;
    logic [PIPE_DEPTH-1:0] load_s;
    logic                  full_s;
    logic [MANT_W-1:0]     res_r    [PIPE_DEPTH];
    logic                  carry_r  [PIPE_DEPTH];
    logic                  sign_r   [PIPE_DEPTH];
    logic                  zero_r   [PIPE_DEPTH];
    logic [LZC_W-1:0]      lzc_r    [PIPE_DEPTH];
    logic                  bypass_r [PIPE_DEPTH];
    logic [TAG_W-1:0]      tag_r    [PIPE_DEPTH];

    logic [MANT_W:0]       a_x_s;
    logic [MANT_W:0]       b_x_s;
    logic [MANT_W:0]       ovf_x_s;
    logic [MANT_W:0]       wide_s;
    logic                  carry_s;
    logic                  sign_s;

    // Stage-1 arithmetic on the incoming operands.
    always_comb begin
        a_x_s   = {1'b0, in_mant_a};
        b_x_s   = {1'b0, in_mant_b};
        ovf_x_s = {{MANT_W{1'b0}}, in_shift_ovf};
        wide_s  = '0;
        carry_s = 1'b0;
        sign_s  = 1'b0;
        if (in_bypass) begin
            wide_s = '0;
        end else if (in_sign_a == in_sign_b) begin
            wide_s  = a_x_s + b_x_s;
            carry_s = wide_s[MANT_W];
            sign_s  = in_sign_a;
        end else if (b_x_s > a_x_s) begin
            wide_s = b_x_s - a_x_s - ovf_x_s;
            sign_s = in_sign_b;
        end else if (a_x_s > b_x_s) begin
            wide_s = a_x_s - b_x_s - ovf_x_s;
            sign_s = in_sign_a;
        end else begin
            // Equal magnitudes cancel to +0; borrowing the sticky bit would wrap to all-ones.
            wide_s = '0;
        end
    end

    // A stage can load unless it and every stage after it are full with the sink stalled.
    always_comb begin
        load_s = '0;
        full_s = 1'b1;
        for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
            full_s    = full_s && valid_r[k];
            load_s[k] = !full_s || out_ready;
        end
    end

    assign in_ready = ready_en_r && load_s[0];

    // Pipeline stage registers; stage 1 also derives zero flag and leading-zero count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_r <= 1'b0;
            valid_r    <= '0;
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                res_r[k]    <= '0;
                carry_r[k]  <= 1'b0;
                sign_r[k]   <= 1'b0;
                zero_r[k]   <= 1'b0;
                lzc_r[k]    <= '0;
                bypass_r[k] <= 1'b0;
                tag_r[k]    <= '0;
            end
        end else begin
            ready_en_r <= 1'b1;
            if (load_s[0]) begin
                valid_r[0] <= in_valid && ready_en_r;
                if (in_valid && ready_en_r) begin
                    res_r[0]    <= wide_s[MANT_W-1:0];
                    carry_r[0]  <= carry_s;
                    sign_r[0]   <= sign_s;
                    bypass_r[0] <= in_bypass;
                    tag_r[0]    <= in_tag;
                end
            end
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                if (load_s[k]) begin
                    valid_r[k] <= valid_r[k-1];
                    if (valid_r[k-1]) begin
                        res_r[k]    <= res_r[k-1];
                        carry_r[k]  <= carry_r[k-1];
                        sign_r[k]   <= sign_r[k-1];
                        bypass_r[k] <= bypass_r[k-1];
                        tag_r[k]    <= tag_r[k-1];
                        lzc_r[k]    <= (k == 1) ? lzc_f(res_r[0]) : lzc_r[k-1];
                        zero_r[k]   <= (k == 1) ? ((res_r[0] == '0) && !carry_r[0]) : zero_r[k-1];
                    end
                end
            end
        end
    end

    assign out_valid  = valid_r[PIPE_DEPTH-1];
    assign out_result = res_r[PIPE_DEPTH-1];
    assign out_carry  = carry_r[PIPE_DEPTH-1];
    assign out_sign   = sign_r[PIPE_DEPTH-1];
    assign out_zero   = zero_r[PIPE_DEPTH-1];
    assign out_lzc    = lzc_r[PIPE_DEPTH-1];
    assign out_bypass = bypass_r[PIPE_DEPTH-1];
    assign out_tag    = tag_r[PIPE_DEPTH-1];

endmodule

// File: tb/tb_pipelined_mantissa_alu.sv
// Directed, table-driven bench for pipelined_mantissa_alu (MANT_W=24, PIPE_DEPTH=2).
module tb_pipelined_mantissa_alu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_bypass;
    logic        in_sign_a;
    logic        in_sign_b;
    logic [23:0] in_mant_a;
    logic [23:0] in_mant_b;
    logic        in_shift_ovf;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_result;
    logic        out_carry;
    logic        out_sign;
    logic        out_zero;
    logic [4:0]  out_lzc;
    logic        out_bypass;
    logic [3:0]  out_tag;

    pipelined_mantissa_alu #(.MANT_W(24), .PIPE_DEPTH(2), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_bypass(in_bypass),
        .in_sign_a(in_sign_a), .in_sign_b(in_sign_b),
        .in_mant_a(in_mant_a), .in_mant_b(in_mant_b),
        .in_shift_ovf(in_shift_ovf), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_carry(out_carry), .out_sign(out_sign),
        .out_zero(out_zero), .out_lzc(out_lzc), .out_bypass(out_bypass),
        .out_tag(out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        byp;
        logic        sa;
        logic        sb;
        logic [23:0] a;
        logic [23:0] b;
        logic        ovf;
        logic [3:0]  tag;
        logic [23:0] res;
        logic        carry;
        logic        sign;
        logic        zero;
        logic [4:0]  lzc;
    } vec_t;

    vec_t vecs[9];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        in_bypass    = v.byp;
        in_sign_a    = v.sa;
        in_sign_b    = v.sb;
        in_mant_a    = v.a;
        in_mant_b    = v.b;
        in_shift_ovf = v.ovf;
        in_tag       = v.tag;
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int guard;
        int lat;
        @(negedge clk);
        drive(v);
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 10);
        chk({name, "_latency"}, 64'(lat), 64'd2);
        chk({name, "_result"}, 64'(out_result), 64'(v.res));
        chk({name, "_carry"},  64'(out_carry),  64'(v.carry));
        chk({name, "_sign"},   64'(out_sign),   64'(v.sign));
        chk({name, "_zero"},   64'(out_zero),   64'(v.zero));
        chk({name, "_lzc"},    64'(out_lzc),    64'(v.lzc));
        chk({name, "_bypass"}, 64'(out_bypass), 64'(v.byp));
        chk({name, "_tag"},    64'(out_tag),    64'(v.tag));
    endtask

    initial begin
        int          i;
        int          n_out;
        int          cyc;
        int          seen;
        logic        acc;
        logic [23:0] snap_res;
        logic [3:0]  snap_tag;
        logic [4:0]  snap_lzc;
        vec_t        v;

        //            byp   sa    sb    a          b          ovf   tag   res        carry sign  zero  lzc
        vecs[0] = '{1'b0, 1'b0, 1'b0, 24'hC00000, 24'h800000, 1'b0, 4'h1, 24'h400000, 1'b1, 1'b0, 1'b0, 5'd1};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 24'h100000, 24'h300000, 1'b1, 4'h2, 24'h1FFFFF, 1'b0, 1'b1, 1'b0, 5'd3};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 24'hABCDEF, 24'hABCDEF, 1'b1, 4'h3, 24'h000000, 1'b0, 1'b0, 1'b1, 5'd24};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 24'hFFFFFF, 24'h000001, 1'b0, 4'hA, 24'h000000, 1'b0, 1'b0, 1'b1, 5'd24};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 24'h800000, 24'h000001, 1'b1, 4'h5, 24'h7FFFFE, 1'b0, 1'b1, 1'b0, 5'd1};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 24'h000001, 24'h000002, 1'b0, 4'h6, 24'h000003, 1'b0, 1'b1, 1'b0, 5'd22};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 24'h800000, 24'h800000, 1'b0, 4'h7, 24'h000000, 1'b1, 1'b0, 1'b0, 5'd24};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 4'h8, 24'hFFFFFE, 1'b1, 1'b1, 1'b0, 5'd0};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 24'h000001, 24'h000000, 1'b1, 4'h9, 24'h000000, 1'b0, 1'b1, 1'b1, 5'd24};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive(vecs[0]);

        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd0);
        chk("rst_out_lzc",   64'(out_lzc),   64'd0);
        chk("rst_out_result", 64'(out_result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ready_before_edge", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 chk("ready_after_edge", 64'(in_ready), 64'd1);

        for (int k = 0; k < 9; k++) begin
            run_vec(vecs[k], $sformatf("vec%0d", k));
        end

        // Back-to-back stream of tags 0..7 with a 3-cycle sink stall.
        i     = 0;
        n_out = 0;
        cyc   = 0;
        v     = vecs[0];
        while (n_out < 8 && cyc < 60) begin
            @(negedge clk);
            out_ready = !(cyc >= 4 && cyc <= 6);
            v.byp = 1'b0; v.sa = 1'b0; v.sb = 1'b0; v.ovf = 1'b0;
            v.a   = 24'(i);
            v.b   = 24'd1;
            v.tag = 4'(i);
            drive(v);
            in_valid = (i < 8);
            #1;
            if (cyc >= 4 && cyc <= 6) begin
                chk("stall_in_ready", 64'(in_ready), 64'd0);
                chk("stall_out_valid", 64'(out_valid), 64'd1);
                if (cyc > 4) begin
                    chk("stall_hold_result", 64'(out_result), 64'(snap_res));
                    chk("stall_hold_tag",    64'(out_tag),    64'(snap_tag));
                    chk("stall_hold_lzc",    64'(out_lzc),    64'(snap_lzc));
                end
                snap_res = out_result;
                snap_tag = out_tag;
                snap_lzc = out_lzc;
            end
            if (out_valid && out_ready) begin
                chk("stream_tag",    64'(out_tag),    64'(n_out));
                chk("stream_result", 64'(out_result), 64'(n_out + 1));
                n_out++;
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) i++;
            cyc++;
        end
        chk("stream_count", 64'(n_out), 64'd8);
        chk("stream_cycles", 64'(cyc), 64'd13);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("stream_no_dup", 64'(out_valid), 64'd0);

        // Async reset with two ops in flight.
        @(negedge clk);
        drive(vecs[4]);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drive(vecs[5]);
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_in_ready",  64'(in_ready),  64'd0);
        chk("async_rst_result",    64'(out_result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("no_ghost_after_reset", 64'(seen), 64'd0);
        run_vec(vecs[1], "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
